seg_scan_mux: RTL

Time-multiplexed N-digit seven-segment display driver: the parametrised successor to the single-digit hex-to-segment decoder. It snapshots a packed vector of hex nibbles once per frame and scans the digits in turn, with per-digit decimal point, per-digit blanking, optional leading-zero suppression and anti-ghosting guard cycles. It sits between the datapath (values to display) and the board's common-anode display pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_mux_rom.sv | 11 +
 rtl/seg_scan_mux.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low a..g patterns (a at bit 6) for nibble values 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SCAN = 1'b1;

endpackage

// File: rtl/seg_scan_mux_rom.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module hex_seg_rom
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit common-anode display driver with per-frame snapshot,
// blanking, leading-zero suppression and anti-ghosting guard cycles.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned DIV      = 50000,
    parameter int unsigned GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_en,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int unsigned HEX_W = 4 * N_DIGITS;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [HEX_W-1:0]    hex_q;
    logic [N_DIGITS-1:0] dp_q, blank_q;
    logic                lz_q;
    logic                load;
    logic [N_DIGITS-1:0] an_d;
    logic [7:0]          sseg_d;
    logic                tick_d;

    logic [3:0] nib_sel;
    logic       dp_sel, blank_sel, lz_hit, active, guard_done;
    logic [6:0] seg_c;

    hex_seg_rom u_rom (
        .nib_i (nib_sel),
        .seg_c (seg_c)
    );

    // Digit selection and zero-suppression for the digit currently scanned
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        lz_hit    = lz_q && (idx_q != '0);
        for (int unsigned j = 0; j < N_DIGITS; j++) begin
            if (idx_q == IDX_W'(j)) begin
                nib_sel   = hex_q[4*j +: 4];
                dp_sel    = dp_q[j];
                blank_sel = blank_q[j];
            end
            if ((IDX_W'(j) >= idx_q) && (hex_q[4*j +: 4] != 4'h0)) begin
                lz_hit = 1'b0;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        load       = 1'b0;
        tick_d     = 1'b0;
        an_d       = '1;
        sseg_d     = 8'hFF;
        active     = (state_q == ST_SCAN) && en;
        guard_done = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) > (CNT_W+1)'(GUARD);

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            default: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == CNT_W'(DIV - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                        idx_d  = '0;
                        load   = 1'b1;
                        tick_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        if (active) begin
            for (int unsigned j = 0; j < N_DIGITS; j++) begin
                if (guard_done && (idx_q == IDX_W'(j))) begin
                    an_d[j] = 1'b0;
                end
            end
            if (blank_sel) begin
                sseg_d = 8'hFF;
            end else if (lz_hit) begin
                sseg_d = {~dp_sel, SEG_OFF};
            end else begin
                sseg_d = {~dp_sel, seg_c};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            hex_q      <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            lz_q       <= 1'b0;
            an         <= '1;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            an         <= an_d;
            sseg       <= sseg_d;
            frame_tick <= tick_d;
            if (load) begin
                hex_q   <= hex_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
                lz_q    <= lz_en;
            end
        end
    end

endmodule
